// File: rtl/upc_pkg.sv
// Shared definitions for the micro-controller front end: default widths,
// fetch-visible opcode constants and the fetch state type.
package upc_pkg;

   localparam int PC_WIDTH_DEF  = 8;
   localparam int INS_WIDTH_DEF = 13;

   // Opcodes occupy the top five instruction bits.
   localparam logic [4:0] OPC_NOP  = 5'b11110;
   localparam logic [4:0] OPC_HALT = 5'b11111;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry data+pc holding buffer for the fetch stage; catches the word
// that lands while the consumer is stalled.
module fetch_skid_buf #(
   parameter int DW = 13,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          load,
   input  logic          unload,
   input  logic [DW-1:0] load_data,
   input  logic [AW-1:0] load_pc,
   output logic [DW-1:0] data,
   output logic [AW-1:0] pc,
   output logic          valid
);

   // A simultaneous unload and load simply replaces the entry.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         data <= load_data;
         pc   <= load_pc;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, program memory read issue and the
// instruction register feeding the decoder. Define FETCH_HALT_EN for HALT.
module instruction_fetch
   import upc_pkg::*;
#(
   parameter int PC_WIDTH  = PC_WIDTH_DEF,
   parameter int INS_WIDTH = INS_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [PC_WIDTH-1:0]  pm_addr,
   output logic                 pm_re,
   input  logic [INS_WIDTH-1:0] pm_data,
   output logic [INS_WIDTH-1:0] ins,
   output logic                 ins_valid,
   output logic [PC_WIDTH-1:0]  ins_pc,
   input  logic                 stall,
   input  logic                 jump_en,
   input  logic [PC_WIDTH-1:0]  jump_addr,
   output logic                 halted
);

   localparam logic [INS_WIDTH-1:0] NOP_INS = {OPC_NOP, {(INS_WIDTH-5){1'b0}}};

   fetch_state_t state, state_nxt;

   logic [PC_WIDTH-1:0]  fetch_pc;
   logic                 pend;
   logic [PC_WIDTH-1:0]  pend_pc;
   logic                 consume;
   logic                 halt_take;
   logic                 jump_take;
   logic                 issue;
   logic                 ins_free;
   logic                 skid_load;
   logic                 skid_unload;
   logic                 skid_valid;
   logic [INS_WIDTH-1:0] skid_data;
   logic [PC_WIDTH-1:0]  skid_pc;

   assign consume = ins_valid & ~stall;

`ifdef FETCH_HALT_EN
   assign halt_take = consume & (ins[INS_WIDTH-1 -: 5] == OPC_HALT);
   assign halted    = (state == HALT);
`else
   assign halt_take = 1'b0;
   assign halted    = 1'b0;
`endif

   // HALT wins over a jump presented on the same instruction.
   assign jump_take   = consume & jump_en & ~halt_take;
   assign ins_free    = ~ins_valid | (consume & ~skid_valid);
   assign skid_load   = pend & ~ins_free & ~jump_take & ~halt_take;
   assign skid_unload = consume & skid_valid;
   assign pm_addr     = fetch_pc;
   assign pm_re       = issue;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         RUN: begin
            issue = ~rst & ~stall & ~jump_take & ~halt_take;
            if (halt_take) begin
               state_nxt = HALT;
            end
         end
         HALT: begin
            issue = 1'b0;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= '0;
         pend     <= 1'b0;
         pend_pc  <= '0;
      end else begin
         pend <= issue;
         if (jump_take) begin
            fetch_pc <= jump_addr;
         end else if (issue) begin
            fetch_pc <= fetch_pc + 1'b1;
            pend_pc  <= fetch_pc;
         end
      end
   end

   // Next instruction comes from skid first, then the word arriving now.
   always_ff @(posedge clk) begin
      if (rst) begin
         ins       <= NOP_INS;
         ins_pc    <= '0;
         ins_valid <= 1'b0;
      end else if (jump_take || halt_take) begin
         ins       <= NOP_INS;
         ins_valid <= 1'b0;
      end else if (skid_unload) begin
         ins       <= skid_data;
         ins_pc    <= skid_pc;
         ins_valid <= 1'b1;
      end else if (pend && ins_free) begin
         ins       <= pm_data;
         ins_pc    <= pend_pc;
         ins_valid <= 1'b1;
      end else if (consume) begin
         ins       <= NOP_INS;
         ins_valid <= 1'b0;
      end
   end

   fetch_skid_buf #(
      .DW(INS_WIDTH),
      .AW(PC_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (jump_take | halt_take),
      .load      (skid_load),
      .unload    (skid_unload),
      .load_data (pm_data),
      .load_pc   (pend_pc),
      .data      (skid_data),
      .pc        (skid_pc),
      .valid     (skid_valid)
   );

endmodule
